// File: rtl/instr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_arb_pkg
//  Description : Shared constants and types for the instruction-side AXI3
//                read arbiter: requester indices, the idle grant code,
//                the arbiter state encoding and AXI burst type.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_arb_pkg;

    // Requester slots on the shared port
    localparam logic [1:0] REQ_ICACHE   = 2'd0;
    localparam logic [1:0] REQ_UNCACHED = 2'd1;
    localparam logic [1:0] REQ_PREFETCH = 2'd2;

    // Reported grant index when no transaction is owned
    localparam logic [1:0] GRANT_NONE   = 2'd3;

    // AXI burst type used for every request
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Prefetch starvation counter geometry (saturating)
    localparam int unsigned STARVE_W   = 3;
    localparam logic [STARVE_W-1:0] STARVE_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage : instr_arb_pkg
`default_nettype wire

// File: rtl/instr_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : instr_arb_pick
//  Description : Combinational priority picker with prefetch aging. The
//                lowest requesting index wins unless prefetch is requesting
//                and has lost at least STARVE_LIM arbitrations in a row.
//  Ports       : valid      - per-requester request vector
//                starve_cnt - consecutive lost prefetch arbitrations
//                winner     - selected requester index
//                found      - at least one requester is valid
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_arb_pick
    import instr_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic [2:0]          valid,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic [1:0]          winner,
    output logic                found
);

    // One extra bit so a limit equal to the counter range compares cleanly
    localparam logic [STARVE_W:0] c_lim = (STARVE_W+1)'(STARVE_LIM);

    logic w_aged;

    assign w_aged = valid[REQ_PREFETCH] && ({1'b0, starve_cnt} >= c_lim);
    assign found  = |valid;

    always_comb begin
        winner = REQ_ICACHE;
        if (w_aged) begin
            winner = REQ_PREFETCH;
        end else if (valid[REQ_ICACHE]) begin
            winner = REQ_ICACHE;
        end else if (valid[REQ_UNCACHED]) begin
            winner = REQ_UNCACHED;
        end else if (valid[REQ_PREFETCH]) begin
            winner = REQ_PREFETCH;
        end
    end

endmodule : instr_arb_pick
`default_nettype wire

// File: rtl/instr_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : instr_rd_arbiter
//  Description : Shares one AXI3 read master between icache refill (0),
//                uncached fetch (1) and icache prefetch (2). One transaction
//                outstanding; fixed priority with prefetch aging; R beats
//                are steered back to the owning requester.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                s_ar*              - per-requester request side (packed)
//                s_r*               - per-requester read data side
//                ar*/r*             - AXI3 AR and R channels
//                grant              - owner index, 3 when idle
//                busy               - transaction in flight
//                id_err             - sticky rid/arid disagreement flag
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_rd_arbiter
    import instr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    // requester side
    input  logic [2:0]          s_arvalid,
    input  logic [3*ADDR_W-1:0] s_araddr,
    input  logic [11:0]         s_arlen,
    input  logic [8:0]          s_arsize,
    output logic [2:0]          s_arready,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic [2:0]          s_rvalid,
    input  logic [2:0]          s_rready,
    // AXI AR channel
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    // AXI R channel
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // status
    output logic [1:0]          grant,
    output logic                busy,
    output logic                id_err
);

    arb_state_t          r_state;
    logic [1:0]          r_winner;
    logic [1:0]          r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_len;
    logic [2:0]          r_size;
    logic [STARVE_W-1:0] r_starve;
    logic                r_id_err;

    logic [1:0]          w_win;
    logic                w_found;
    logic                w_accept;
    logic                w_r_hs;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [3:0]          w_sel_len;
    logic [2:0]          w_sel_size;

    instr_arb_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .valid      (s_arvalid),
        .starve_cnt (r_starve),
        .winner     (w_win),
        .found      (w_found)
    );

    // Reset dominates the grant edge, so the accept pulse is held off while
    // rst is high to avoid telling a requester it was taken when it was not.
    assign w_accept  = (r_state == IDLE) && w_found && !rst;
    assign s_arready = w_accept ? (3'b001 << w_win) : 3'b000;

    // Fields of the winning requester, captured on the accept cycle
    always_comb begin
        w_sel_addr = s_araddr[ADDR_W-1:0];
        w_sel_len  = s_arlen[3:0];
        w_sel_size = s_arsize[2:0];
        case (w_win)
            REQ_UNCACHED: begin
                w_sel_addr = s_araddr[2*ADDR_W-1:ADDR_W];
                w_sel_len  = s_arlen[7:4];
                w_sel_size = s_arsize[5:3];
            end
            REQ_PREFETCH: begin
                w_sel_addr = s_araddr[3*ADDR_W-1:2*ADDR_W];
                w_sel_len  = s_arlen[11:8];
                w_sel_size = s_arsize[8:6];
            end
            default: begin
                w_sel_addr = s_araddr[ADDR_W-1:0];
                w_sel_len  = s_arlen[3:0];
                w_sel_size = s_arsize[2:0];
            end
        endcase
    end

    // AR channel driven from the latched request
    assign arvalid = (r_state == ADDR);
    assign arid    = {2'b00, r_winner};
    assign araddr  = r_addr;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // R channel: zero-latency steering to the owner, data broadcast
    assign rready   = (r_state == DATA) && s_rready[r_winner];
    assign s_rvalid = ((r_state == DATA) && rvalid) ? (3'b001 << r_winner) : 3'b000;
    assign s_rdata  = rdata;
    assign s_rresp  = rresp;
    assign s_rlast  = rlast;
    assign w_r_hs   = rvalid && rready;

    assign grant  = r_grant;
    assign busy   = (r_state != IDLE);
    assign id_err = r_id_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_winner <= REQ_ICACHE;
            r_grant  <= GRANT_NONE;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_starve <= '0;
            r_id_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_winner <= w_win;
                        r_grant  <= w_win;
                        r_addr   <= w_sel_addr;
                        r_len    <= w_sel_len;
                        r_size   <= w_sel_size;
                        r_state  <= ADDR;
                        // Aging: count only rounds prefetch actually lost
                        if (w_win == REQ_PREFETCH) begin
                            r_starve <= '0;
                        end else if (s_arvalid[REQ_PREFETCH] && (r_starve != STARVE_MAX)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    // Beat is still forwarded; the flag only records it
                    if (w_r_hs && (rid != arid)) begin
                        r_id_err <= 1'b1;
                    end
                    // rlast alone ends the burst, no beat counting
                    if (w_r_hs && rlast) begin
                        r_state <= IDLE;
                        r_grant <= GRANT_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : instr_rd_arbiter
`default_nettype wire

// File: tb/tb_instr_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_rd_arbiter
//  Description : Directed self-checking bench for instr_rd_arbiter: reset
//                values, single refill, contention with prefetch aging,
//                AR/R backpressure, wrong rid and reset mid-burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_rd_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned STARVE_LIM = 4;

    logic                clk;
    logic                rst;
    logic [2:0]          s_arvalid;
    logic [3*ADDR_W-1:0] s_araddr;
    logic [11:0]         s_arlen;
    logic [8:0]          s_arsize;
    logic [2:0]          s_arready;
    logic [31:0]         s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic [2:0]          s_rvalid;
    logic [2:0]          s_rready;
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [1:0]          grant;
    logic                busy;
    logic                id_err;

    int checks = 0;
    int errors = 0;

    instr_rd_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arlock    (arlock),
        .arcache   (arcache),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .grant     (grant),
        .busy      (busy),
        .id_err    (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one further unit later, well before the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        s_arvalid = 3'b000;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_rready  = 3'b111;
        arready   = 1'b0;
        rid       = 4'd0;
        rdata     = 32'd0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_arvalid",   64'(arvalid),   64'd0);
        check("rst_rready",    64'(rready),    64'd0);
        check("rst_s_arready", 64'(s_arready), 64'd0);
        check("rst_s_rvalid",  64'(s_rvalid),  64'd0);
        check("rst_grant",     64'(grant),     64'd3);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_id_err",    64'(id_err),    64'd0);
        check("rst_ar_fields", 64'({araddr, arlen, arsize, arid}), 64'd0);
        check("rst_starve",    64'(dut.r_starve), 64'd0);

        // ---------------- single refill ----------------
        tick();
        s_arvalid       = 3'b001;
        s_araddr[31:0]  = 32'h1FC0_0000;
        s_arlen[3:0]    = 4'd7;
        s_arsize[2:0]   = 3'd2;
        settle();
        check("refill_s_arready", 64'(s_arready), 64'b001);
        tick();
        s_arvalid = 3'b000;
        settle();
        check("refill_arvalid", 64'(arvalid), 64'd1);
        check("refill_araddr",  64'(araddr),  64'h1FC0_0000);
        check("refill_arlen_id_burst_size",
              64'({arlen, arid, arburst, arsize}), 64'({4'd7, 4'd0, 2'b01, 3'd2}));
        check("refill_lock_cache_prot", 64'({arlock, arcache, arprot}), 64'd0);
        check("refill_busy_grant", 64'({busy, grant}), 64'({1'b1, 2'd0}));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rvalid = 1'b1;
            rid    = 4'd0;
            rdata  = 32'hC0DE_0000 + 32'(i);
            rlast  = (i == 7);
            settle();
            check($sformatf("refill_beat%0d", i),
                  64'({s_rvalid, rready, s_rlast, s_rdata}),
                  64'({3'b001, 1'b1, (i == 7), 32'hC0DE_0000 + 32'(i)}));
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        check("refill_done_busy_grant", 64'({busy, grant}), 64'({1'b0, 2'd3}));

        // ---------------- contention with aging ----------------
        begin
            logic [1:0] exp_win [5];
            exp_win[0] = 2'd0; exp_win[1] = 2'd0; exp_win[2] = 2'd0;
            exp_win[3] = 2'd0; exp_win[4] = 2'd2;
            s_arvalid = 3'b111;
            s_araddr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
            s_arlen   = {4'd1, 4'd2, 4'd3};
            s_arsize  = {3'd2, 3'd2, 3'd2};
            for (int k = 0; k < 5; k++) begin
                settle();
                check($sformatf("cont%0d_s_arready", k), 64'(s_arready),
                      64'(3'b001 << exp_win[k]));
                tick();
                check($sformatf("cont%0d_grant_arid", k), 64'({grant, arid}),
                      64'({exp_win[k], 2'b00, exp_win[k]}));
                arready = 1'b1;
                tick();
                arready = 1'b0;
                rvalid  = 1'b1;
                rlast   = 1'b1;
                rid     = {2'b00, exp_win[k]};
                settle();
                tick();
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
            s_arvalid = 3'b000;
            settle();
            check("cont_araddr_prefetch", 64'(araddr), 64'h0000_3000);
            check("cont_starve_cleared", 64'(dut.r_starve), 64'd0);
        end

        // ---------------- backpressure + wrong id ----------------
        s_arvalid         = 3'b010;
        s_araddr[63:32]   = 32'h0000_2040;
        s_arlen[7:4]      = 4'd3;
        settle();
        check("bp_s_arready", 64'(s_arready), 64'b010);
        tick();
        // Uncached drops its fields; refill raises a request mid-transaction
        s_araddr[63:32] = 32'hDEAD_BEEF;
        s_arlen[7:4]    = 4'd9;
        s_arvalid       = 3'b001;
        s_araddr[31:0]  = 32'h1FC0_0100;
        s_arlen[3:0]    = 4'd0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("bp_ar_hold%0d", c),
                  64'({arvalid, arid, arlen, araddr, s_arready}),
                  64'({1'b1, 4'd1, 4'd3, 32'h0000_2040, 3'b000}));
            tick();
        end
        arready = 1'b1;
        tick();
        arready  = 1'b0;
        s_rready = 3'b101;
        rvalid   = 1'b1;
        rid      = 4'd1;
        rdata    = 32'hAAAA_0000;
        settle();
        check("bp_rready_low", 64'({rready, s_rvalid}), 64'({1'b0, 3'b010}));
        tick();
        s_rready = 3'b111;
        rid      = 4'd2;
        settle();
        check("wrongid_forwarded", 64'({rready, s_rvalid, s_rdata}),
              64'({1'b1, 3'b010, 32'hAAAA_0000}));
        check("wrongid_not_yet", 64'(id_err), 64'd0);
        tick();
        check("wrongid_id_err", 64'(id_err), 64'd1);
        rid = 4'd1;
        for (int b = 0; b < 3; b++) begin
            rlast = (b == 2);
            settle();
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        check("bp_next_refill_accept", 64'({busy, s_arready}), 64'({1'b0, 3'b001}));
        tick();
        s_arvalid = 3'b000;
        settle();
        check("bp_next_refill_ar", 64'({arid, araddr}), 64'({4'd0, 32'h1FC0_0100}));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rid     = 4'd0;
        settle();
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        check("id_err_sticky", 64'({id_err, busy, grant}), 64'({1'b1, 1'b0, 2'd3}));

        // ---------------- reset mid-burst ----------------
        s_arvalid      = 3'b001;
        s_araddr[31:0] = 32'h1FC0_0200;
        s_arlen[3:0]   = 4'd7;
        settle();
        tick();
        s_arvalid = 3'b000;
        arready   = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1;
            rid    = 4'd0;
            settle();
            tick();
        end
        rst = 1'b1;
        settle();
        tick();
        check("rstmid_busy_arvalid_rready", 64'({busy, arvalid, rready}), 64'd0);
        check("rstmid_grant_id_err", 64'({grant, id_err}), 64'({2'd3, 1'b0}));
        check("rstmid_s_rvalid", 64'(s_rvalid), 64'd0);
        check("rstmid_ar_fields", 64'({araddr, arlen, arid}), 64'd0);
        rst    = 1'b0;
        rvalid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_rd_arbiter
`default_nettype wire
